// File: rtl/apb_slave_regfile.sv
// APB completer with a small 32-bit register file: word 0 is a read-only ID, words 1..NREGS-1 are R/W.
// Define APB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states per transfer; otherwise every transfer is zero-wait.
module apb_slave_regfile #(
    parameter int          NREGS       = 8,
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] ID_VALUE    = 32'hA0B0_0001,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [31:0]          PADDR,
    input  logic                 PWRITE,
    input  logic [31:0]          PWDATA,
    input  logic                 PSELx,
    input  logic                 PENABLE,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic [NREGS*32-1:0]  o_regs,
    output logic [NREGS-1:0]     o_wr_pulse
);
    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1
`ifdef APB_SLAVE_WAIT_EN
        , WAIT = 2'd2
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       regs [NREGS];
    logic [IDX_W-1:0]  idx_q, a_idx, cur_idx;
    logic              wr_q, err_q, a_err, cur_err, cur_wr;
    logic [31:0]       wdata_q, rd_word, prdata_q;
    logic              pslverr_q, setup, commit, enter_rdy, leave_rdy;
    logic [NREGS-1:0]  wr_pulse_q;

    // Decode straight from the bus during setup; later cycles use the latched copy.
    assign a_idx = PADDR[ADDR_W-1:2];
    assign a_err = (PADDR[1:0] != 2'b00)
                 | ((PADDR >> ADDR_W) != 32'd0)
                 | (32'(a_idx) >= NREGS)
                 | (PWRITE & (a_idx == '0));

    assign setup   = (state_q == IDLE) & PSELx & ~PENABLE;
    assign cur_idx = (state_q == IDLE) ? a_idx  : idx_q;
    assign cur_err = (state_q == IDLE) ? a_err  : err_q;
    assign cur_wr  = (state_q == IDLE) ? PWRITE : wr_q;
    assign commit  = (state_q == READY) & PSELx & PENABLE & wr_q & ~err_q;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NREGS; i++)
            if (cur_idx == IDX_W'(i)) rd_word = regs[i];
    end

`ifdef APB_SLAVE_WAIT_EN
    logic [3:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            cnt_q <= '0;
        else if (setup)
            cnt_q <= 4'(WAIT_CYCLES);
        else if (state_q == WAIT && cnt_q != '0)
            cnt_q <= cnt_q - 4'd1;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (setup) begin
`ifdef APB_SLAVE_WAIT_EN
                state_d = (WAIT_CYCLES != 0) ? WAIT : READY;
`else
                state_d = READY;
`endif
            end
`ifdef APB_SLAVE_WAIT_EN
            WAIT: begin
                if (!PSELx)           state_d = IDLE;
                else if (cnt_q <= 4'd1) state_d = READY;
            end
`endif
            READY: if (!PSELx || PENABLE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_rdy = (state_d == READY) & (state_q != READY);
    assign leave_rdy = (state_q == READY) & (state_d != READY);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
            wr_pulse_q <= '0;
        end else begin
            state_q <= state_d;
            if (setup) begin
                idx_q   <= a_idx;
                wr_q    <= PWRITE;
                err_q   <= a_err;
                wdata_q <= PWDATA;
            end
            // Read data is captured once, on entry to READY; errored reads and writes show 0.
            if (enter_rdy) begin
                prdata_q  <= (!cur_err && !cur_wr) ? rd_word : 32'd0;
                pslverr_q <= cur_err;
            end else if (leave_rdy) begin
                prdata_q  <= '0;
                pslverr_q <= 1'b0;
            end
            for (int i = 0; i < NREGS; i++)
                wr_pulse_q[i] <= commit && (idx_q == IDX_W'(i));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_word
            if (g == 0) begin : g_id
                assign regs[g] = ID_VALUE;
            end else begin : g_rw
                always_ff @(posedge i_clk or negedge i_reset_n) begin
                    if (!i_reset_n)
                        regs[g] <= '0;
                    else if (commit && idx_q == IDX_W'(g))
                        regs[g] <= wdata_q;
                end
            end
            assign o_regs[32*g +: 32] = regs[g];
        end
    endgenerate

    assign PREADY     = (state_q == READY);
    assign PRDATA     = prdata_q;
    assign PSLVERR    = pslverr_q;
    assign o_wr_pulse = wr_pulse_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed table-driven bench for apb_slave_regfile (NREGS=8), plus hand-written abort/reset/back-to-back sequences.
module tb_apb_slave_regfile;
    localparam int NREGS = 8;
`ifdef APB_SLAVE_WAIT_EN
    localparam int WAITS = 2;
`else
    localparam int WAITS = 0;
`endif
    localparam logic [31:0] ID = 32'hA0B0_0001;

    logic                i_clk = 1'b0;
    logic                i_reset_n = 1'b0;
    logic [31:0]         PADDR = '0;
    logic                PWRITE = 1'b0;
    logic [31:0]         PWDATA = '0;
    logic                PSELx = 1'b0;
    logic                PENABLE = 1'b0;
    logic [31:0]         PRDATA;
    logic                PREADY;
    logic                PSLVERR;
    logic [NREGS*32-1:0] o_regs;
    logic [NREGS-1:0]    o_wr_pulse;

    int total = 0;
    int bad = 0;

    apb_slave_regfile #(
        .NREGS(NREGS), .ADDR_W(8), .ID_VALUE(ID), .WAIT_CYCLES(2)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSELx(PSELx), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .o_regs(o_regs), .o_wr_pulse(o_wr_pulse)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0]      addr;
        logic             wr;
        logic [31:0]      wdata;
        logic [31:0]      exp_rdata;
        logic             exp_err;
        logic [NREGS-1:0] exp_pulse;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at #1 after an edge; returns at #1 after the completing edge with the bus idle,
    // so back-to-back calls give a setup phase right after each completion.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic err,
                        output logic [NREGS-1:0] pulse, output int waits);
        PSELx = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d;
        @(posedge i_clk); #1;
        PENABLE = 1'b1;
        waits = 0;
        while (!PREADY && waits < 20) begin
            @(posedge i_clk); #1;
            waits++;
        end
        rd = PRDATA; err = PSLVERR;
        @(posedge i_clk); #1;
        pulse = o_wr_pulse;
        PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    function automatic logic [31:0] word(input int i);
        return o_regs[32*i +: 32];
    endfunction

    initial begin
        logic [31:0]      rd, orx;
        logic             err;
        logic [NREGS-1:0] pulse;
        int               waits;

        vecs[0]  = '{32'h00, 1'b0, 32'h0,        ID,           1'b0, 8'h00};
        vecs[1]  = '{32'h04, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 8'h02};
        vecs[2]  = '{32'h04, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 8'h00};
        vecs[3]  = '{32'h00, 1'b1, 32'h11111111, 32'h0,        1'b1, 8'h00};
        vecs[4]  = '{32'h06, 1'b1, 32'h22222222, 32'h0,        1'b1, 8'h00};
        vecs[5]  = '{32'h20, 1'b1, 32'h33333333, 32'h0,        1'b1, 8'h00};
        vecs[6]  = '{32'h20, 1'b0, 32'h0,        32'h0,        1'b1, 8'h00};
        vecs[7]  = '{32'h1C, 1'b1, 32'h00000077, 32'h0,        1'b0, 8'h80};
        vecs[8]  = '{32'h1C, 1'b0, 32'h0,        32'h00000077, 1'b0, 8'h00};
        vecs[9]  = '{32'h104, 1'b0, 32'h0,       32'h0,        1'b1, 8'h00};
        vecs[10] = '{32'h04, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 8'h00};
        vecs[11] = '{32'h08, 1'b1, 32'hCAFE0008, 32'h0,        1'b0, 8'h04};
        vecs[12] = '{32'h08, 1'b0, 32'h0,        32'hCAFE0008, 1'b0, 8'h00};

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_pulse", 32'(o_wr_pulse), 32'd0);
        chk("rst_word1", word(1), 32'd0);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        for (int i = 0; i < 13; i++) begin
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, err, pulse, waits);
            chk($sformatf("v%0d_waits", i), 32'(waits), 32'(WAITS));
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_pulse", i), 32'(pulse), 32'(vecs[i].exp_pulse));
        end
        chk("regs_w0", word(0), ID);
        chk("regs_w1", word(1), 32'hDEADBEEF);
        chk("regs_w2", word(2), 32'hCAFE0008);
        chk("regs_w3", word(3), 32'd0);
        chk("regs_w7", word(7), 32'h00000077);

        // Strobe lasts exactly one cycle.
        xfer(32'h10, 1'b1, 32'h000000A5, rd, err, pulse, waits);
        chk("pulse_on", 32'(pulse), 32'h10);
        @(posedge i_clk); #1;
        chk("pulse_off", 32'(o_wr_pulse), 32'd0);
        chk("w4_written", word(4), 32'h000000A5);

        // Abort: drop PSELx right after setup, before the access phase completes.
        PSELx = 1'b1; PENABLE = 1'b0; PADDR = 32'h14; PWRITE = 1'b1; PWDATA = 32'h55;
        @(posedge i_clk); #1;
        chk("abort_ready_before", 32'(PREADY), (WAITS == 0) ? 32'd1 : 32'd0);
        PSELx = 1'b0;
        @(posedge i_clk); #1;
        chk("abort_pready", 32'(PREADY), 32'd0);
        @(posedge i_clk); #1;
        chk("abort_pulse", 32'(o_wr_pulse), 32'd0);
        chk("abort_w5", word(5), 32'd0);

        // Reset in the middle of a transfer after a committed write.
        xfer(32'h0C, 1'b1, 32'h00001234, rd, err, pulse, waits);
        chk("w3_pulse", 32'(pulse), 32'h08);
        chk("w3_val", word(3), 32'h00001234);
        PSELx = 1'b1; PENABLE = 1'b0; PADDR = 32'h08; PWRITE = 1'b0;
        @(posedge i_clk); #1;
        PENABLE = 1'b1;
        i_reset_n = 1'b0;
        #1;
        chk("mid_rst_pready", 32'(PREADY), 32'd0);
        chk("mid_rst_prdata", PRDATA, 32'd0);
        orx = '0;
        for (int i = 1; i < NREGS; i++) orx |= word(i);
        chk("mid_rst_regs_clear", orx, 32'd0);
        chk("mid_rst_id", word(0), ID);
        PSELx = 1'b0; PENABLE = 1'b0;
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        xfer(32'h0C, 1'b0, 32'h0, rd, err, pulse, waits);
        chk("post_rst_read", rd, 32'd0);
        chk("post_rst_waits", 32'(waits), 32'(WAITS));

        // Back-to-back write then read with no idle cycle between.
        xfer(32'h04, 1'b1, 32'h00000001, rd, err, pulse, waits);
        chk("b2b_wr_pulse", 32'(pulse), 32'h02);
        xfer(32'h04, 1'b0, 32'h0, rd, err, pulse, waits);
        chk("b2b_rd", rd, 32'h00000001);
        chk("b2b_err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
